// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared constants and state encoding for the sequential multiplier
package mult_pkg;

    localparam int WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } state_t;

    // Iteration counter must hold 0..w-1; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

    localparam int CNT_W_DEF = cnt_width(WIDTH_DEF);

endpackage

// File: rtl/mult_negate.sv
// rtl/mult_negate.sv - conditional two's-complement negate
module mult_negate #(
    parameter int W = 64
) (
    input  logic         i_neg,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data
);

    assign o_data = i_neg ? (~i_data + W'(1)) : i_data;

endmodule

// File: rtl/mult_seq.sv
// rtl/mult_seq.sv - sequential shift-add multiplier, signed/unsigned, one iteration per cycle
module mult_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic             Signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int CW = cnt_width(WIDTH);

    state_t             r_state;
    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH:0]   r_acc;
    logic               r_neg;
    logic [CW-1:0]      r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_neg_a;
    logic               w_neg_b;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic               w_zero;
    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH:0]   w_shift;
    logic [2*WIDTH-1:0] w_prod_fixed;
    logic               w_last;

    assign w_neg_a = Signed & A[WIDTH-1];
    assign w_neg_b = Signed & B[WIDTH-1];

    // Most negative value negates to itself, which read as unsigned is the correct magnitude.
    mult_negate #(.W(WIDTH)) u_mag_a (
        .i_neg  (w_neg_a),
        .i_data (A),
        .o_data (w_mag_a)
    );

    mult_negate #(.W(WIDTH)) u_mag_b (
        .i_neg  (w_neg_b),
        .i_data (B),
        .o_data (w_mag_b)
    );

    mult_negate #(.W(2*WIDTH)) u_fix (
        .i_neg  (r_neg),
        .i_data (r_acc[2*WIDTH-1:0]),
        .o_data (w_prod_fixed)
    );

    assign w_zero = ~(|w_mag_a) | ~(|w_mag_b);

    // Single datapath adder: upper accumulator (WIDTH+1 bits) plus gated multiplicand.
    assign w_addend = r_acc[0] ? r_mcand : '0;
    assign w_sum    = r_acc[2*WIDTH:WIDTH] + {1'b0, w_addend};
    assign w_shift  = {1'b0, w_sum, r_acc[WIDTH-1:1]};
    assign w_last   = (r_cnt == CW'(WIDTH-1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_mcand <= '0;
            r_acc   <= '0;
            r_neg   <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (Start) begin
                        r_mcand <= w_mag_a;
                        r_neg   <= w_neg_a ^ w_neg_b;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        if (w_zero) begin
                            r_acc   <= '0;
                            r_state <= SIGN;
                        end else begin
                            r_acc   <= {{(WIDTH+1){1'b0}}, w_mag_b};
                            r_state <= RUN;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_acc <= w_shift;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_state <= SIGN;
                    end
                end
                SIGN: begin
                    r_hi    <= w_prod_fixed[2*WIDTH-1:WIDTH];
                    r_lo    <= w_prod_fixed[WIDTH-1:0];
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= DONE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign Busy = r_busy;
    assign Done = r_done;
    assign Hi   = r_hi;
    assign Lo   = r_lo;

endmodule

// File: tb/tb_mult_seq.sv
// tb/tb_mult_seq.sv - self-checking bench for mult_seq with expected-result scoreboard
module tb_mult_seq;

    logic        CLK = 1'b0;
    logic        RST;
    logic        Start;
    logic        Signed;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic        Done;
    logic [31:0] Hi;
    logic [31:0] Lo;

    int          n_checks = 0;
    int          n_err    = 0;
    logic [63:0] exp_q[$];
    logic [63:0] last_res;

    mult_seq #(.WIDTH(32)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .Start  (Start),
        .Signed (Signed),
        .A      (A),
        .B      (B),
        .Busy   (Busy),
        .Done   (Done),
        .Hi     (Hi),
        .Lo     (Lo)
    );

    always #5 CLK = ~CLK;

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        if (s) return sa * sb;
        return {32'b0, a} * {32'b0, b};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the acceptance edge.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                            input logic [63:0] exp);
        A      = a;
        B      = b;
        Signed = s;
        Start  = 1'b1;
        exp_q.push_back(exp);
        @(posedge CLK);
        @(negedge CLK);
        Start  = 1'b0;
        A      = $urandom;
        B      = $urandom;
        Signed = 1'($urandom_range(0, 1));
        check("busy_after_accept", {63'b0, Busy}, 64'd1);
        check("hilo_hold_at_accept", {Hi, Lo}, last_res);
    endtask

    task automatic wait_done(input string tag, input int exp_lat, input bit inject);
        int          lat = 0;
        int          busy_cyc = 1;
        logic [63:0] exp;
        while (!Done && lat < 100) begin
            if (inject && lat == 10) begin
                Start  = 1'b1;
                A      = $urandom;
                B      = $urandom;
                Signed = 1'($urandom_range(0, 1));
            end else begin
                Start = 1'b0;
            end
            @(posedge CLK);
            lat++;
            @(negedge CLK);
            if (Busy) busy_cyc++;
        end
        Start = 1'b0;
        check({tag, "_done"}, {63'b0, Done}, 64'd1);
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_busy_cycles"}, 64'(busy_cyc), 64'(exp_lat));
        if (exp_q.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 64'd0, 64'd1);
        end else begin
            exp = exp_q.pop_front();
            check({tag, "_result"}, {Hi, Lo}, exp);
        end
        last_res = {Hi, Lo};
    endtask

    task automatic idle_check(input string tag);
        @(posedge CLK);
        @(negedge CLK);
        check({tag, "_done_pulse_one_cycle"}, {63'b0, Done}, 64'd0);
        check({tag, "_busy_idle"}, {63'b0, Busy}, 64'd0);
        check({tag, "_hilo_hold"}, {Hi, Lo}, last_res);
    endtask

    initial begin
        int          done_seen;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;

        RST    = 1'b1;
        Start  = 1'b1;
        Signed = 1'b0;
        A      = 32'd5;
        B      = 32'd5;
        last_res = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset_busy", {63'b0, Busy}, 64'd0);
        check("reset_done", {63'b0, Done}, 64'd0);
        check("reset_hilo", {Hi, Lo}, 64'd0);
        Start = 1'b0;
        RST   = 1'b0;
        @(negedge CLK);

        start_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001);
        wait_done("umax", 33, 1'b0);
        idle_check("umax");

        start_op(32'hFFFFFFFD, 32'd7, 1'b1, 64'hFFFFFFFF_FFFFFFEB);
        wait_done("s_m3x7", 33, 1'b0);
        idle_check("s_m3x7");

        start_op(32'hFFFFFFFD, 32'd7, 1'b0, 64'h00000006_FFFFFFEB);
        wait_done("u_m3x7", 33, 1'b0);
        idle_check("u_m3x7");

        start_op(32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000);
        wait_done("s_min_sq", 33, 1'b0);
        idle_check("s_min_sq");

        start_op(32'h80000000, 32'd1, 1'b1, 64'hFFFFFFFF_80000000);
        wait_done("s_min_x1", 33, 1'b0);
        idle_check("s_min_x1");

        start_op(32'h00000000, 32'h12345678, 1'b0, 64'd0);
        wait_done("zero_a", 1, 1'b0);
        idle_check("zero_a");

        start_op(32'hFFFFFFFF, 32'h00000000, 1'b1, 64'd0);
        wait_done("zero_b_signed", 1, 1'b0);
        idle_check("zero_b_signed");

        start_op(32'h00001234, 32'hFFFFFFFB, 1'b1, 64'hFFFFFFFF_FFFFA4FC);
        wait_done("start_ignored", 33, 1'b1);
        idle_check("start_ignored");

        start_op(32'hDEADBEEF, 32'h00001000, 1'b0, 64'h00000DEA_DBEEF000);
        wait_done("b2b_first", 33, 1'b0);
        start_op(32'd7, 32'h80000000, 1'b1, 64'hFFFFFFFC_80000000);
        wait_done("b2b_second", 33, 1'b0);
        idle_check("b2b_second");

        start_op(32'h11111111, 32'h22222222, 1'b0, model(32'h11111111, 32'h22222222, 1'b0));
        for (int i = 0; i < 15; i++) begin
            @(posedge CLK);
            @(negedge CLK);
        end
        RST = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        check("abort_busy", {63'b0, Busy}, 64'd0);
        check("abort_done", {63'b0, Done}, 64'd0);
        check("abort_hilo", {Hi, Lo}, 64'd0);
        RST = 1'b0;
        void'(exp_q.pop_back());
        last_res  = '0;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            if (Done) done_seen++;
        end
        check("abort_no_done", 64'(done_seen), 64'd0);

        for (int k = 0; k < 6; k++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'(k % 2);
            start_op(ra, rb, rs, model(ra, rb, rs));
            wait_done("random", (ra == 0 || rb == 0) ? 1 : 33, 1'b0);
            idle_check("random");
        end

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
